// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to binary converter.
// One digit is folded in per clock, most significant first, as
// acc = acc*10 + digit. The multiply-by-ten is built from two shifts
// and an add, so no multiplier or divider is needed. A conversion
// takes NDIGITS edges after the start edge. Any digit above 9 marks
// the result invalid: data is forced to zero and bcd_err is raised.
module bcd_to_bin #(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 32
) (
  input  logic                   in_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [OUT_W-1:0]       data,
  output logic                   bcd_err
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t                 state;
  logic [4*NDIGITS-1:0]   sreg;
  logic [OUT_W-1:0]       acc;
  logic [CNT_W-1:0]       cnt;
  logic                   err;

  logic [3:0]             digit;
  logic [OUT_W-1:0]       acc_nxt;
  logic                   err_nxt;

  // acc*10 + d, wrapping modulo 2^OUT_W
  function automatic logic [OUT_W-1:0] mac10(input logic [OUT_W-1:0] a,
                                             input logic [3:0]       d);
    logic [OUT_W-1:0] d_ext;
    d_ext = {{(OUT_W-4){1'b0}}, d};
    return (a << 3) + (a << 1) + d_ext;
  endfunction

  // Next accumulator value and sticky error for the digit at the top of the shift register
  always_comb begin
    digit   = sreg[4*NDIGITS-1 -: 4];
    acc_nxt = mac10(acc, digit);
    err_nxt = err | (digit > 4'd9);
  end

  // Control FSM with registered outputs: capture in IDLE, one digit per edge in CONV
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
      bcd_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= bcd_in;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            bcd_err <= 1'b0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_nxt;
          sreg <= sreg << 4;
          cnt  <= cnt + CNT_W'(1);
          err  <= err_nxt;
          // Last digit: publish the result, the error includes this digit
          if (cnt == LAST_CNT) begin
            data    <= err_nxt ? '0 : acc_nxt;
            bcd_err <= err_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and randomized bench for bcd_to_bin (NDIGITS=4, OUT_W=32).
module tb_bcd_to_bin;

  localparam int NDIGITS = 4;
  localparam int OUT_W   = 32;

  logic                 in_clk;
  logic                 rst;
  logic                 start;
  logic [4*NDIGITS-1:0] bcd_in;
  logic                 busy;
  logic                 done;
  logic [OUT_W-1:0]     data;
  logic                 bcd_err;

  int total;
  int bad;

  bcd_to_bin #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
    .in_clk (in_clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .data   (data),
    .bcd_err(bcd_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digit string, zero if any digit is not decimal
  function automatic void model(input logic [4*NDIGITS-1:0] b,
                                output logic [OUT_W-1:0] v, output logic e);
    longint sum;
    longint weight;
    int     d;
    sum    = 0;
    weight = 1;
    e      = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      sum    = sum + longint'(d) * weight;
      weight = weight * 10;
    end
    v = e ? '0 : OUT_W'(sum);
  endfunction

  // One full conversion from IDLE, checking every cycle of the latency
  task automatic run_conv(input string tag, input logic [4*NDIGITS-1:0] b);
    logic [OUT_W-1:0] ev;
    logic             ee;
    model(b, ev, ee);
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check({tag, ".busy_on"}, 64'(busy), 64'd1);
    check({tag, ".err_clr"}, 64'(bcd_err), 64'd0);
    for (int i = 1; i < NDIGITS; i++) begin
      tick();
      check({tag, ".no_early_done"}, 64'(done), 64'd0);
    end
    tick();
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_off"}, 64'(busy), 64'd0);
    check({tag, ".data"}, 64'(data), 64'(ev));
    check({tag, ".bcd_err"}, 64'(bcd_err), 64'(ee));
    tick();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".data_hold"}, 64'(data), 64'(ev));
  endtask

  initial begin
    logic [4*NDIGITS-1:0] r;
    logic [4*NDIGITS-1:0] first;
    logic [OUT_W-1:0]     ev;
    logic                 ee;
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    start  = 1'b0;
    bcd_in = '0;

    // Reset state
    tick();
    tick();
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.data", 64'(data), 64'd0);
    check("rst.bcd_err", 64'(bcd_err), 64'd0);
    rst = 1'b1;
    tick();

    // Basic directed values
    run_conv("t1_1234", 16'h1234);
    check("t1_val", 64'(data), 64'd1234);
    run_conv("t2_9999", 16'h9999);
    check("t2_val", 64'(data), 64'h270F);
    run_conv("t2_0000", 16'h0000);

    // Invalid digit, then recovery
    run_conv("t3_12A4", 16'h12A4);
    check("t3_err_hold", 64'(bcd_err), 64'd1);
    run_conv("t3_recover", 16'h0815);

    // start held high: a result every NDIGITS+1 cycles
    bcd_in = 16'h0042;
    start  = 1'b1;
    for (int k = 1; k <= 3 * (NDIGITS + 1); k++) begin
      tick();
      check("t4_done", 64'(done), 64'((k % (NDIGITS + 1)) == 0));
      check("t4_busy", 64'(busy), 64'((k % (NDIGITS + 1)) != 0));
      if (done) check("t4_data", 64'(data), 64'd42);
    end
    start = 1'b0;
    tick();
    check("t4_stop", 64'(busy), 64'd0);

    // start and new bcd_in during CONV are ignored
    first = 16'h3141;
    model(first, ev, ee);
    bcd_in = first;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    bcd_in = 16'h9876;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    check("t5_done", 64'(done), 64'd1);
    check("t5_data", 64'(data), 64'(ev));
    tick();
    check("t5_no_requeue", 64'(busy), 64'd0);

    // Randomized conversions, mixing all-decimal and arbitrary nibbles
    for (int n = 0; n < 24; n++) begin
      if (n % 2 == 0) begin
        r = '0;
        for (int i = 0; i < NDIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      end else begin
        r = 16'($urandom);
      end
      run_conv("rand", r);
    end

    // Asynchronous reset in the middle of a conversion
    run_conv("t6_pre", 16'h0777);
    bcd_in = 16'h5555;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("t6.busy", 64'(busy), 64'd0);
    check("t6.done", 64'(done), 64'd0);
    check("t6.data", 64'(data), 64'd0);
    check("t6.bcd_err", 64'(bcd_err), 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < NDIGITS + 2; i++) begin
      tick();
      check("t6.no_done", 64'(done), 64'd0);
    end
    run_conv("t6_after", 16'h0567);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
